// File: rtl/axi_lite_timer_regs.sv
// AXI4-Lite register front-end for a countdown timer core: CTRL/LOAD/STATUS/ID
// registers, start/stop pulse generation and a sticky, edge-detected expiry flag.
module axi_lite_timer_regs #(
    parameter logic [31:0] ID_VALUE = 32'h0000_0100,
    parameter logic [31:0] LOAD_RST = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [3:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,

    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [3:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,

    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic [31:0] load_value,
    output logic        start,
    output logic        stop,
    input  logic        expired,
    output logic        irq
);

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_LOAD   = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_ID     = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Handshake state
    logic        awready_q, awready_d;
    logic        bvalid_q,  bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;

    // Register file and timer-control state
    logic [31:0] load_q,         load_d;
    logic        irq_en_q,       irq_en_d;
    logic        expired_flag_q, expired_flag_d;
    logic        running_q,      running_d;
    logic        expired_prev_q;
    logic        start_q,        start_d;
    logic        stop_q,         stop_d;

    logic        wr_en;
    logic        rd_en;
    logic [1:0]  wr_sel;
    logic [1:0]  rd_sel;
    logic        ctrl_wr;
    logic        load_wr;
    logic        status_w1c;
    logic        expired_edge;
    logic [31:0] rd_word;
    logic [31:0] load_merged;
    logic        unused_addr_bits;

    assign wr_sel = s_axi_awaddr[3:2];
    assign rd_sel = s_axi_araddr[3:2];
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A transfer completes only on a cycle where the registered ready is
    // presented and the master still holds valid.
    assign wr_en = awready_q && s_axi_awvalid && s_axi_wvalid;
    assign rd_en = arready_q && s_axi_arvalid;

    assign ctrl_wr      = wr_en && (wr_sel == SEL_CTRL) && s_axi_wstrb[0];
    assign load_wr      = wr_en && (wr_sel == SEL_LOAD);
    assign status_w1c   = wr_en && (wr_sel == SEL_STATUS) && s_axi_wstrb[0] && s_axi_wdata[0];
    assign expired_edge = expired && !expired_prev_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
            assign load_merged[gi*8 +: 8] = (load_wr && s_axi_wstrb[gi])
                                            ? s_axi_wdata[gi*8 +: 8]
                                            : load_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_word = 32'd0;
        case (rd_sel)
            SEL_CTRL:   rd_word = {29'd0, irq_en_q, 2'b00};
            SEL_LOAD:   rd_word = load_q;
            SEL_STATUS: rd_word = {30'd0, running_q, expired_flag_q};
            SEL_ID:     rd_word = ID_VALUE;
            default:    rd_word = 32'd0;
        endcase
    end

    always_comb begin
        awready_d = !awready_q && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
        arready_d = !arready_q && s_axi_arvalid && !rvalid_q;

        bvalid_d = bvalid_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        load_d   = load_merged;
        irq_en_d = ctrl_wr ? s_axi_wdata[CTRL_IRQ_EN] : irq_en_q;

        // STOP dominates when both command bits are written together.
        start_d = ctrl_wr && s_axi_wdata[CTRL_START] && !s_axi_wdata[CTRL_STOP];
        stop_d  = ctrl_wr && s_axi_wdata[CTRL_STOP];

        expired_flag_d = expired_flag_q;
        if (expired_edge) begin
            expired_flag_d = 1'b1;
        end else if (status_w1c) begin
            expired_flag_d = 1'b0;
        end

        // A start pulse beats a coincident expiry so a restart is never lost.
        running_d = running_q;
        if (start_q) begin
            running_d = 1'b1;
        end else if (stop_q || expired_edge) begin
            running_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            awready_q      <= 1'b0;
            bvalid_q       <= 1'b0;
            arready_q      <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= 32'd0;
            load_q         <= LOAD_RST;
            irq_en_q       <= 1'b0;
            expired_flag_q <= 1'b0;
            running_q      <= 1'b0;
            expired_prev_q <= 1'b0;
            start_q        <= 1'b0;
            stop_q         <= 1'b0;
        end else begin
            awready_q      <= awready_d;
            bvalid_q       <= bvalid_d;
            arready_q      <= arready_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            load_q         <= load_d;
            irq_en_q       <= irq_en_d;
            expired_flag_q <= expired_flag_d;
            running_q      <= running_d;
            expired_prev_q <= expired;
            start_q        <= start_d;
            stop_q         <= stop_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

    assign load_value = load_q;
    assign start      = start_q;
    assign stop       = stop_q;
    assign irq        = expired_flag_q && irq_en_q;

endmodule
